uart_loader: RTL and testbench

//  UART boot loader: the writer side of the ram_memory write port. Receives a framed program

---
 rtl/uart_loader_if.sv | 30 +++
 rtl/uart_loader.sv | 147 ++++++++++++++
 tb/tb_uart_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Byte-stream, reply and RAM-write signals between the UART boot loader and its neighbours.
// master = loader side, slave = buart / RAM / CPU-reset side.
interface uart_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_busy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        mem_write_enable;
  logic [15:0] mem_write_addr;
  logic [15:0] mem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output rx_rd, tx_wr, tx_data,
    output mem_write_enable, mem_write_addr, mem_write_data,
    output cpu_hold, load_done, load_error
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  rx_rd, tx_wr, tx_data,
    input  mem_write_enable, mem_write_addr, mem_write_data,
    input  cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: parses SYNC/LEN/data/CHK frames from the buart, writes 16-bit words
// into RAM, holds the CPU in reset until a frame checks good, and replies ACK or NAK.
module uart_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [23:0] TIMEOUT   = 24'd600000,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic          clk,
  input  logic          reset,
  uart_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_RESP
  } state_t;

  state_t      state;
  logic        rd_d;
  logic [7:0]  hi_byte;
  logic [7:0]  chk_acc;
  logic [7:0]  resp_byte;
  logic [15:0] len;
  logic [15:0] idx;
  logic [23:0] tmo;

  logic        accept;
  logic        in_frame;
  logic [15:0] len_w;
  logic [15:0] idx_next;

  // The buart needs a cycle after rx_rd to drop rx_valid, so skip both the strobe cycle and the next.
  assign accept   = bus.rx_valid && !bus.rx_rd && !rd_d && (state != S_RESP);
  assign in_frame = (state != S_IDLE) && (state != S_RESP);
  assign len_w    = {hi_byte, bus.rx_data};
  assign idx_next = idx + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      rd_d                 <= 1'b0;
      hi_byte              <= '0;
      chk_acc              <= '0;
      resp_byte            <= '0;
      len                  <= '0;
      idx                  <= '0;
      tmo                  <= '0;
      bus.rx_rd            <= 1'b0;
      bus.tx_wr            <= 1'b0;
      bus.tx_data          <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_write_addr   <= '0;
      bus.mem_write_data   <= '0;
      bus.cpu_hold         <= 1'b1;
      bus.load_done        <= 1'b0;
      bus.load_error       <= 1'b0;
    end else begin
      bus.rx_rd            <= accept;
      rd_d                 <= bus.rx_rd;
      bus.mem_write_enable <= 1'b0;
      bus.tx_wr            <= 1'b0;

      // Inter-byte silence counter, only meaningful once a frame has started.
      if (in_frame && !accept) tmo <= tmo + 24'd1;
      else                     tmo <= '0;

      if (in_frame && !accept && (tmo == TIMEOUT - 24'd1)) begin
        resp_byte      <= NAK_BYTE;
        bus.load_error <= 1'b1;
        state          <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && (bus.rx_data == SYNC_BYTE)) begin
              bus.cpu_hold   <= 1'b1;
              bus.load_done  <= 1'b0;
              bus.load_error <= 1'b0;
              chk_acc        <= '0;
              state          <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (accept) begin
              hi_byte <= bus.rx_data;
              state   <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (accept) begin
              len <= len_w;
              idx <= '0;
              if (len_w == 16'd0) begin
                state <= S_CHK;
              end else if (len_w > 16'(MEM_WORDS)) begin
                resp_byte      <= NAK_BYTE;
                bus.load_error <= 1'b1;
                state          <= S_RESP;
              end else begin
                state <= S_DATA_HI;
              end
            end
          end
          S_DATA_HI: begin
            if (accept) begin
              hi_byte <= bus.rx_data;
              chk_acc <= chk_acc ^ bus.rx_data;
              state   <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (accept) begin
              chk_acc              <= chk_acc ^ bus.rx_data;
              bus.mem_write_enable <= 1'b1;
              bus.mem_write_addr   <= idx;
              bus.mem_write_data   <= {hi_byte, bus.rx_data};
              idx                  <= idx_next;
              state                <= (idx_next == len) ? S_CHK : S_DATA_HI;
            end
          end
          S_CHK: begin
            if (accept) begin
              if (bus.rx_data == chk_acc) begin
                resp_byte     <= ACK_BYTE;
                bus.load_done <= 1'b1;
                bus.cpu_hold  <= 1'b0;
              end else begin
                resp_byte      <= NAK_BYTE;
                bus.load_error <= 1'b1;
              end
              state <= S_RESP;
            end
          end
          S_RESP: begin
            if (!bus.tx_busy) begin
              bus.tx_wr   <= 1'b1;
              bus.tx_data <= resp_byte;
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames plus random frames checked
// against a frame-level reference model.
module tb_uart_loader;
  localparam logic [23:0] TMO = 24'd300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_loader_if bus();
  uart_loader #(.TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          rd_cnt = 0;
  logic [31:0] exp_w[$];
  logic [7:0]  exp_tx;
  bit          exp_ack;

  // Observe DUT strobes away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_write_enable) wr_q.push_back({bus.mem_write_addr, bus.mem_write_data});
      if (bus.tx_wr) tx_q.push_back(bus.tx_data);
      if (bus.rx_rd) rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behaves like the buart: present byte, drop rx_valid one cycle after seeing rx_rd.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_rd && n < 20);
    check("rx_rd_strobe", 32'(bus.rx_rd), 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int budget);
    int n = 0;
    while (tx_q.size() == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("tx_within_budget", 32'(tx_q.size() != 0), 32'd1);
  endtask

  // Frame-level expectation: first SYNC, 16-bit word count, complete pairs get written,
  // ACK only when the checksum byte is present and equals the XOR of all data bytes.
  task automatic model();
    int i = 0;
    int n;
    logic [7:0] x = 8'h00;
    exp_w.delete();
    exp_ack = 1'b0;
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    n = int'({frame[i+1], frame[i+2]});
    if (n <= 4096) begin
      for (int k = 0; k < n; k++)
        if (i + 4 + 2*k < frame.size())
          exp_w.push_back({16'(k), frame[i+3+2*k], frame[i+4+2*k]});
      for (int k = i + 3; k < i + 3 + 2*n && k < frame.size(); k++) x ^= frame[k];
      exp_ack = (i + 3 + 2*n < frame.size()) && (frame[i+3+2*n] == x);
    end
    exp_tx = exp_ack ? 8'h06 : 8'h15;
  endtask

  task automatic run_frame(input string tag, input int budget);
    wr_q.delete();
    tx_q.delete();
    rd_cnt = 0;
    foreach (frame[k]) send_byte(frame[k]);
    wait_tx(budget);
    repeat (2) @(negedge clk);
    model();
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'd1);
    check({tag, "_tx_byte"}, 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 32'(exp_tx));
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_w.size()));
    for (int k = 0; k < wr_q.size() && k < exp_w.size(); k++)
      check({tag, "_wr"}, wr_q[k], exp_w[k]);
    check({tag, "_done"}, 32'(bus.load_done), 32'(exp_ack));
    check({tag, "_error"}, 32'(bus.load_error), 32'(!exp_ack));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!exp_ack));
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'(frame.size()));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_outputs", 32'({bus.rx_rd, bus.tx_wr, bus.mem_write_enable, bus.load_done, bus.load_error}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame("good2", 50);
    frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame("badchk", 50);
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("lead_drop", 50);
    frame = '{8'hA5, 8'h10, 8'h01};
    run_frame("oversize", 20);
    frame = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    run_frame("timeout", int'(TMO) + 50);
    frame = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00};
    run_frame("sync_as_data", 50);

    // Random frames, some with a corrupted checksum or truncated.
    for (int r = 0; r < 8; r++) begin
      int n;
      logic [7:0] x;
      logic [7:0] b;
      n = int'($urandom_range(0, 5));
      x = 8'h00;
      frame.delete();
      if ($urandom_range(0, 1) == 1) frame.push_back(8'($urandom_range(0, 8'hA4)));
      frame.push_back(8'hA5);
      frame.push_back(8'h00);
      frame.push_back(8'(n));
      for (int k = 0; k < 2*n; k++) begin
        b = 8'($urandom);
        x ^= b;
        frame.push_back(b);
      end
      case ($urandom_range(0, 3))
        0:       frame.push_back(x ^ 8'(1 << $urandom_range(0, 7)));
        1:       if (frame.size() > 3) void'(frame.pop_back()); else frame.push_back(x);
        default: frame.push_back(x);
      endcase
      run_frame("random", int'(TMO) + 50);
    end

    // rx_valid held across the strobe and the latency cycle: one accept only.
    wr_q.delete(); tx_q.delete(); rd_cnt = 0;
    @(negedge clk);
    bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("hold_valid_one_rd", 32'(rd_cnt), 32'd1);
    bus.tx_busy = 1'b1;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    repeat (10) @(negedge clk);
    check("busy_no_tx", 32'(tx_q.size()), 32'd0);
    bus.tx_busy = 1'b0;
    wait_tx(20);
    check("busy_tx_byte", 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 32'h06);
    check("hold_valid_wr", wr_q.size() > 0 ? wr_q[0] : 32'h0, 32'h0000_1234);
    check("hold_valid_rd_total", 32'(rd_cnt), 32'd6);

    // Reset in the middle of the data phase.
    wr_q.delete(); tx_q.delete(); rd_cnt = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    #2 reset = 1'b1;
    #1 check("midrst_hold", 32'(bus.cpu_hold), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h44);
    repeat (TMO + 20) @(negedge clk);
    check("midrst_wr_count", 32'(wr_q.size()), 32'd1);
    check("midrst_no_tx", 32'(tx_q.size()), 32'd0);
    check("midrst_flags", 32'({bus.load_done, bus.load_error}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
